// File: rtl/pwm_modulator_if.sv
// Sample/flag bundle between an audio sample source and the PWM modulator.
// The source drives the master side, and the modulator uses the slave side.
interface pwm_modulator_if;
    logic [15:0] sample_in;
    logic        sample_rdy;
    logic        flags_clr;
    logic        pwm_out;
    logic        sample_ready;
    logic        overflow;
    logic        underrun;

    modport master (
        output sample_in, sample_rdy, flags_clr,
        input  pwm_out, sample_ready, overflow, underrun
    );

    modport slave (
        input  sample_in, sample_rdy, flags_clr,
        output pwm_out, sample_ready, overflow, underrun
    );
endinterface

// File: rtl/pwm_modulator.sv
// PWM modulator: 16-bit two's-complement samples go through a small FIFO into a one-period duty register.
// Optional macro PWM_UNDERRUN_MUTE_EN: on underrun, load midscale duty instead of repeating the last sample.
module pwm_modulator #(
    parameter int PERIOD_BITS = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    pwm_modulator_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PERIOD_BITS-1:0] CNT_MAX = '1;
    localparam logic [PERIOD_BITS-1:0] DUTY_MID = {1'b1, {(PERIOD_BITS-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_reg, state_next;
    logic [PERIOD_BITS-1:0]  cnt_reg, cnt_next;
    logic [PERIOD_BITS-1:0]  duty_reg, duty_next;
    logic [AW:0]             wr_ptr_reg, rd_ptr_reg;
    logic                    overflow_reg, overflow_next;
    logic                    underrun_reg, underrun_next;
    logic [15:0]             fifo_mem [FIFO_DEPTH];

    logic                    fifo_empty, fifo_full;
    logic                    pop, push, drop, underrun_set;
    logic [15:0]             head_sample;
    logic [PERIOD_BITS-1:0]  head_duty;
    logic [15-PERIOD_BITS:0] unused_head_lsbs;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // Offset-binary conversion: flip the sign bit and keep the top PERIOD_BITS bits.
    assign head_sample      = fifo_mem[rd_ptr_reg[AW-1:0]];
    assign head_duty        = {~head_sample[15], head_sample[14:16-PERIOD_BITS]};
    assign unused_head_lsbs = head_sample[15-PERIOD_BITS:0];

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        duty_next    = duty_reg;
        pop          = 1'b0;
        underrun_set = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    duty_next  = head_duty;
                    state_next = RUN;
                end
            end
            RUN: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_MAX) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        duty_next = head_duty;
                    end else begin
                        underrun_set = 1'b1;
`ifdef PWM_UNDERRUN_MUTE_EN
                        duty_next = DUTY_MID;
`endif
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A pop on the same edge frees a slot, so a strobe into a full FIFO still lands.
    assign push = bus.sample_rdy && (!fifo_full || pop);
    assign drop = bus.sample_rdy && fifo_full && !pop;

    assign overflow_next = drop         | (overflow_reg & ~bus.flags_clr);
    assign underrun_next = underrun_set | (underrun_reg & ~bus.flags_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            duty_reg     <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            duty_reg     <= duty_next;
            overflow_reg <= overflow_next;
            underrun_reg <= underrun_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= bus.sample_in;
    end

    assign bus.pwm_out      = (state_reg == RUN) && (cnt_reg < duty_reg);
    assign bus.sample_ready = !fifo_full;
    assign bus.overflow     = overflow_reg;
    assign bus.underrun     = underrun_reg;
endmodule

// File: tb/tb_pwm_modulator.sv
// Self-checking bench for pwm_modulator (PERIOD_BITS=8, FIFO_DEPTH=4).
// Per-period high counts are queued as expectations when samples are strobed in and checked as each period completes.
module tb_pwm_modulator;
    logic clk;
    logic rst;
    pwm_modulator_if bus();

    pwm_modulator #(.PERIOD_BITS(8), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sample;
        int          exp_high;
    } vec_t;

    localparam int NVEC = 8;
`ifdef PWM_UNDERRUN_MUTE_EN
    localparam int UR_HIGH = 128;
`else
    localparam int UR_HIGH = 192;
`endif

    vec_t tbl [NVEC];
    int   sb_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic strobe(input logic [15:0] v);
        bus.sample_in  = v;
        bus.sample_rdy = 1'b1;
        @(negedge clk);
        bus.sample_rdy = 1'b0;
    endtask

    // Counts pwm_out over one full period (counter 0..255); optionally strobes a sample at cycle 10.
    task automatic measure_period(input bit incl_now, input bit sen, input logic [15:0] sval,
                                  input int sexp, output int highs, output logic first);
        int n0;
        highs = 0;
        first = 1'b0;
        n0 = incl_now ? 1 : 0;
        if (incl_now) begin
            first = bus.pwm_out;
            highs = bus.pwm_out ? 1 : 0;
        end
        for (int i = n0; i < 256; i++) begin
            @(negedge clk);
            if (i == 0) first = bus.pwm_out;
            if (bus.pwm_out) highs++;
            bus.sample_rdy = 1'b0;
            if (sen && i == 10) begin
                bus.sample_in  = sval;
                bus.sample_rdy = 1'b1;
                sb_q.push_back(sexp);
            end
        end
    endtask

    task automatic check_period(input string name, input int highs);
        int exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d expected <none queued>", name, highs);
        end else begin
            exp = sb_q.pop_front();
            check(name, highs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          highs;
        int          cnt;
        logic        first;
        logic [15:0] sval;
        int          sexp;
        logic [15:0] ovf_vals [4];
        int          ovf_exp  [4];

        tbl[0] = '{16'h0000, 128};
        tbl[1] = '{16'h8001, 0};
        tbl[2] = '{16'h7FFF, 255};
        tbl[3] = '{16'hC000, 64};
        tbl[4] = '{16'h8000, 0};
        tbl[5] = '{16'hFF7F, 127};
        tbl[6] = '{16'h0080, 128};
        tbl[7] = '{16'h4000, 192};
        ovf_vals[0] = 16'h0000; ovf_exp[0] = 128;
        ovf_vals[1] = 16'hC000; ovf_exp[1] = 64;
        ovf_vals[2] = 16'h8001; ovf_exp[2] = 0;
        ovf_vals[3] = 16'h7FFF; ovf_exp[3] = 255;

        rst = 1'b1;
        bus.sample_in  = '0;
        bus.sample_rdy = 1'b0;
        bus.flags_clr  = 1'b0;
        #3;
        check("rst_pwm_out", bus.pwm_out, 0);
        check("rst_sample_ready", bus.sample_ready, 1);
        check("rst_overflow", bus.overflow, 0);
        check("rst_underrun", bus.underrun, 0);
        wait_neg(2);
        rst = 1'b0;
        wait_neg(2);
        check("idle_pwm_out", bus.pwm_out, 0);

        // Table: each sample plays for exactly one period; the next one is strobed mid-period.
        sb_q.push_back(tbl[0].exp_high);
        strobe(tbl[0].sample);
        check("latency_before_load", bus.pwm_out, 0);
        for (int i = 0; i < NVEC; i++) begin
            sval = (i + 1 < NVEC) ? tbl[i+1].sample : 16'h0000;
            sexp = (i + 1 < NVEC) ? tbl[i+1].exp_high : 0;
            measure_period(1'b0, (i + 1 < NVEC), sval, sexp, highs, first);
            if (i == 0) check("first_cycle_high", first, 1);
            check_period($sformatf("period_%0d_sample_%h", i, tbl[i].sample), highs);
        end
        check("no_underrun_yet", bus.underrun, 0);

        // Underrun: FIFO empty at wrap.
        sb_q.push_back(UR_HIGH);
        measure_period(1'b0, 1'b0, 16'h0000, 0, highs, first);
        check_period("underrun_period", highs);
        check("underrun_flag", bus.underrun, 1);

        // flags_clr on the same edge as another underrun: set wins; then it clears.
        bus.flags_clr = 1'b1;
        @(negedge clk);
        check("underrun_set_wins", bus.underrun, 1);
        @(negedge clk);
        check("underrun_cleared", bus.underrun, 0);
        bus.flags_clr = 1'b0;

        // Fill the FIFO mid-period (counter 1..5), then overflow on a non-wrap cycle.
        for (int k = 0; k < 4; k++) begin
            bus.sample_in  = ovf_vals[k];
            bus.sample_rdy = 1'b1;
            sb_q.push_back(ovf_exp[k]);
            @(negedge clk);
        end
        bus.sample_rdy = 1'b0;
        check("full_sample_ready", bus.sample_ready, 0);
        check("full_no_overflow", bus.overflow, 0);
        strobe(16'h1234);
        check("drop_overflow", bus.overflow, 1);
        check("drop_sample_ready", bus.sample_ready, 0);
        wait_neg(249);
        check("still_full_before_wrap", bus.sample_ready, 0);
        // Strobe on the wrap edge: the pop frees a slot so 0x1234 (duty 0x92) is accepted.
        sb_q.push_back(146);
        strobe(16'h1234);
        check("wrap_push_overflow_kept", bus.overflow, 1);
        check("wrap_push_refull", bus.sample_ready, 0);
        measure_period(1'b1, 1'b0, 16'h0000, 0, highs, first);
        check_period("ovf_period_0", highs);
        for (int k = 1; k < 5; k++) begin
            measure_period(1'b0, 1'b0, 16'h0000, 0, highs, first);
            check_period($sformatf("ovf_period_%0d", k), highs);
        end
        check("scoreboard_drained", sb_q.size(), 0);

        // Reset mid-period with three max-duty samples queued.
        wait_neg(1);
        bus.sample_in  = 16'h7FFF;
        bus.sample_rdy = 1'b1;
        wait_neg(3);
        bus.sample_rdy = 1'b0;
        wait_neg(97);
        check("pre_rst_sample_ready", bus.sample_ready, 1);
        check("pre_rst_underrun", bus.underrun, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_pwm_out", bus.pwm_out, 0);
        check("midrst_sample_ready", bus.sample_ready, 1);
        check("midrst_overflow", bus.overflow, 0);
        check("midrst_underrun", bus.underrun, 0);
        wait_neg(2);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.pwm_out) cnt++;
        end
        check("post_rst_fifo_empty_pwm", cnt, 0);
        sb_q.push_back(128);
        strobe(16'h0000);
        check("restart_latency", bus.pwm_out, 0);
        measure_period(1'b0, 1'b0, 16'h0000, 0, highs, first);
        check("restart_first_high", first, 1);
        check_period("restart_period", highs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_modulator.md
PWM_MODULATOR -- requirements
Module: PWM_modulator

Interface
REQ-001 SHALL have parameter PERIOD_BITS, default 8; PWM period is 2^PERIOD_BITS clocks, legal range 4..12.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; sample FIFO depth, power of two, 2..16.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sample_in  input  16  two's-complement audio sample, already range-reduced upstream.
REQ-006 sample_rdy  input  1  one-cycle strobe; sample_in valid in the same cycle.
REQ-007 flags_clr  input  1  synchronous clear of sticky flags.
REQ-008 pwm_out  output  1  PWM bitstream.
REQ-009 sample_ready  output  1  high when FIFO not full.
REQ-010 overflow  output  1  sticky; a sample was dropped.
REQ-011 underrun  output  1  sticky; period wrap found FIFO empty while RUN.

Function
REQ-012 SHALL write sample_in to FIFO tail on any edge with sample_rdy=1 and FIFO not full; no handshake back-pressure beyond sample_ready.
REQ-013 SHALL drop sample and set overflow when sample_rdy=1 and FIFO full, except same-edge pop frees a slot, then push is accepted.
REQ-014 Duty conversion: u = sample_in with bit 15 inverted (offset binary); duty = u[15:16-PERIOD_BITS].
REQ-015 States: IDLE, RUN. IDLE: counter held 0, pwm_out=0.
REQ-016 IDLE->RUN on first edge with FIFO non-empty: pop head into duty register, counter=0.
REQ-017 RUN: counter increments each clock, wraps 2^PERIOD_BITS-1 -> 0.
REQ-018 pwm_out = RUN and (counter < duty), combinational from registers only; duty 0 gives constant 0, max duty gives high all but one cycle.
REQ-019 At wrap edge in RUN: FIFO non-empty -> pop head into duty register; empty -> underrun=1 and duty per REQ-026.
REQ-020 No push-to-duty bypass: a sample pushed on the wrap edge into an empty FIFO is stored, underrun still set.
REQ-021 Latency: strobe at edge E0 into empty FIFO in IDLE -> duty loaded at E1, pwm_out reflects it from E1 onward.
REQ-022 flags_clr=1 clears overflow and underrun at next edge; a same-edge set event wins.
REQ-023 RUN never returns to IDLE except via reset.

Reset
REQ-024 rst=1 SHALL immediately force: state IDLE, counter 0, duty 0, FIFO empty (pointers 0), overflow 0, underrun 0; hence pwm_out=0, sample_ready=1.
REQ-025 Reset asserted mid-period SHALL abort the period; FIFO contents discarded; after release behaviour per REQ-016.

Configuration
REQ-026 Macro PWM_UNDERRUN_MUTE_EN: defined -> underrun loads midscale duty 2^(PERIOD_BITS-1) (silence); undefined -> duty register retains previous value (repeat last sample). underrun flag set in both builds.

Verification (PERIOD_BITS=8, FIFO_DEPTH=4)
REQ-027 Reset, one strobe sample_in=0x0000 -> duty 128; pwm_out high exactly 128 of 256 cycles, starting the edge after the strobe.
REQ-028 Samples 0x8001 then 0x7FFF in successive periods -> duty 0 (pwm_out constant 0 for 256 cycles), then duty 255 (high 255, low 1).
REQ-029 In RUN with FIFO full, strobe 0x1234 on non-wrap cycle -> sample dropped, overflow=1, sample_ready=0; strobe on wrap edge -> accepted, overflow unchanged.
REQ-030 Load 0x4000 (duty 192), supply no further samples -> at wrap underrun=1; with PWM_UNDERRUN_MUTE_EN duty 128, without it duty stays 192; flags_clr then clears underrun.
REQ-031 Assert rst at counter=100 with 3 samples queued -> pwm_out=0 immediately, FIFO empty, flags 0; new strobe 0x0000 after release restarts per REQ-027.
